// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: dedups stream-prefetch lines into a small FIFO and issues
// them one at a time to DMA, returning each response as a single fill pulse.
module prefetch_issue_queue #(
  parameter int addr_width_p         = 32,
  parameter int data_width_p         = 32,
  parameter int els_p                = 4,
  parameter int block_offset_width_p = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    prefetch_v_i,
  input  logic [addr_width_p-1:0] prefetch_addr_i,
  input  logic                    demand_miss_v_i,
  input  logic [addr_width_p-1:0] demand_miss_addr_i,
  output logic                    dma_req_v_o,
  output logic [addr_width_p-1:0] dma_req_addr_o,
  input  logic                    dma_req_ready_i,
  input  logic                    dma_resp_v_i,
  input  logic [data_width_p-1:0] dma_resp_data_i,
  output logic                    fill_v_o,
  output logic [addr_width_p-1:0] fill_addr_o,
  output logic [data_width_p-1:0] fill_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [15:0]             drop_count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [addr_width_p-1:0] line_mask_lp =
    {addr_width_p{1'b1}} << block_offset_width_p;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;

  state_e                  state_q, state_n;
  logic [ptr_w_lp-1:0]     wr_ptr_q, rd_ptr_q;
  logic [cnt_w_lp-1:0]     cnt_q;
  logic [els_p-1:0]        live_q;
  logic [addr_width_p-1:0] addr_q [els_p];
  logic [addr_width_p-1:0] inflight_q;
  logic [data_width_p-1:0] data_q;
  logic [15:0]             drop_q;

  logic [addr_width_p-1:0] pf_line, dm_line;
  logic [els_p-1:0]        occ, pf_hit, cancel;
  logic                    dup, enq, drop, pop, head_live;

  assign pf_line   = prefetch_addr_i & line_mask_lp;
  assign dm_line   = demand_miss_addr_i & line_mask_lp;
  assign full_o    = (cnt_q == cnt_w_lp'(els_p));
  assign empty_o   = (cnt_q == '0);
  assign head_live = live_q[rd_ptr_q];

  // Slot i is occupied when its distance from the read pointer is below the count.
  always_comb begin
    occ    = '0;
    pf_hit = '0;
    cancel = '0;
    for (int i = 0; i < els_p; i++) begin
      occ[i]    = cnt_w_lp'(ptr_w_lp'(i) - rd_ptr_q) < cnt_q;
      pf_hit[i] = occ[i] && live_q[i] && (addr_q[i] == pf_line);
      cancel[i] = demand_miss_v_i && occ[i] && (addr_q[i] == dm_line) &&
                  !((state_q == REQ) && (rd_ptr_q == ptr_w_lp'(i)));
    end
  end

  assign dup  = (|pf_hit) ||
                (((state_q == WAIT) || (state_q == FILL)) && (inflight_q == pf_line));
  assign enq  = prefetch_v_i && !full_o && !dup;
  assign drop = prefetch_v_i && full_o && !dup;
  assign pop  = ((state_q == IDLE) && !empty_o && !head_live) ||
                ((state_q == REQ) && dma_req_ready_i);

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (!empty_o && head_live) state_n = REQ;
      REQ:  if (dma_req_ready_i)       state_n = WAIT;
      WAIT: if (dma_resp_v_i)          state_n = FILL;
      FILL:                            state_n = IDLE;
      default:                         state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      live_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_n;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({enq, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      for (int i = 0; i < els_p; i++) begin
        if (enq && (wr_ptr_q == ptr_w_lp'(i)))      live_q[i] <= 1'b1;
        else if (pop && (rd_ptr_q == ptr_w_lp'(i))) live_q[i] <= 1'b0;
        else if (cancel[i])                         live_q[i] <= 1'b0;
      end
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Payload storage: only meaningful while qualified by live/state, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq) addr_q[wr_ptr_q] <= pf_line;
    if ((state_q == REQ) && dma_req_ready_i) inflight_q <= addr_q[rd_ptr_q];
    if ((state_q == WAIT) && dma_resp_v_i)   data_q     <= dma_resp_data_i;
  end

  // Outputs are gated by state so they read zero in reset and when idle.
  assign dma_req_v_o    = (state_q == REQ);
  assign dma_req_addr_o = (state_q == REQ)  ? addr_q[rd_ptr_q] : '0;
  assign fill_v_o       = (state_q == FILL);
  assign fill_addr_o    = (state_q == FILL) ? inflight_q : '0;
  assign fill_data_o    = (state_q == FILL) ? data_q : '0;
  assign drop_count_o   = drop_q;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench for prefetch_issue_queue with a request/fill scoreboard.
module tb_prefetch_issue_queue;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        prefetch_v_i;
  logic [31:0] prefetch_addr_i;
  logic        demand_miss_v_i;
  logic [31:0] demand_miss_addr_i;
  logic        dma_req_v_o;
  logic [31:0] dma_req_addr_o;
  logic        dma_req_ready_i;
  logic        dma_resp_v_i;
  logic [31:0] dma_resp_data_i;
  logic        fill_v_o;
  logic [31:0] fill_addr_o;
  logic [31:0] fill_data_o;
  logic        full_o;
  logic        empty_o;
  logic [15:0] drop_count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_fill_addr[$];
  logic [31:0] exp_fill_data[$];

  prefetch_issue_queue dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .prefetch_v_i(prefetch_v_i), .prefetch_addr_i(prefetch_addr_i),
    .demand_miss_v_i(demand_miss_v_i), .demand_miss_addr_i(demand_miss_addr_i),
    .dma_req_v_o(dma_req_v_o), .dma_req_addr_o(dma_req_addr_o),
    .dma_req_ready_i(dma_req_ready_i),
    .dma_resp_v_i(dma_resp_v_i), .dma_resp_data_i(dma_resp_data_i),
    .fill_v_o(fill_v_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .full_o(full_o), .empty_o(empty_o), .drop_count_o(drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: requests popped on handshake, fills popped on each fill pulse.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (dma_req_v_o && dma_req_ready_i) begin
        chk("req_pending", 64'(exp_req.size() > 0), 64'd1);
        if (exp_req.size() > 0) chk("req_addr", 64'(dma_req_addr_o), 64'(exp_req.pop_front()));
      end
      if (fill_v_o) begin
        chk("fill_pending", 64'(exp_fill_addr.size() > 0), 64'd1);
        if (exp_fill_addr.size() > 0) begin
          chk("fill_addr", 64'(fill_addr_o), 64'(exp_fill_addr.pop_front()));
          chk("fill_data", 64'(fill_data_o), 64'(exp_fill_data.pop_front()));
        end
      end
    end
  end

  task automatic pf(input logic [31:0] a);
    prefetch_v_i    = 1'b1;
    prefetch_addr_i = a;
    tick();
    prefetch_v_i    = 1'b0;
  endtask

  // Wait (bounded) for a request, accept it, answer it and let the fill go out.
  task automatic serve_one(input logic [31:0] line, input logic [31:0] data);
    for (int k = 0; k < 20; k++) begin
      if (dma_req_v_o) break;
      tick();
    end
    chk("serve_req_v", 64'(dma_req_v_o), 64'd1);
    chk("serve_req_addr", 64'(dma_req_addr_o), 64'(line));
    dma_req_ready_i = 1'b1;
    tick();
    dma_resp_v_i    = 1'b1;
    dma_resp_data_i = data;
    exp_fill_addr.push_back(line);
    exp_fill_data.push_back(data);
    tick();
    dma_resp_v_i = 1'b0;
    chk("serve_fill_v", 64'(fill_v_o), 64'd1);
    tick();
  endtask

  initial begin
    reset_n_i = 1'b0;
    prefetch_v_i = 1'b0; prefetch_addr_i = '0;
    demand_miss_v_i = 1'b0; demand_miss_addr_i = '0;
    dma_req_ready_i = 1'b0; dma_resp_v_i = 1'b0; dma_resp_data_i = '0;
    #12;
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_req_v", 64'(dma_req_v_o), 64'd0);
    chk("rst_fill_v", 64'(fill_v_o), 64'd0);
    chk("rst_drop", 64'(drop_count_o), 64'd0);
    chk("rst_req_addr", 64'(dma_req_addr_o), 64'd0);
    tick();
    reset_n_i = 1'b1;
    tick();

    // Single prefetch, ready tied high.
    dma_req_ready_i = 1'b1;
    exp_req.push_back(32'h1000);
    pf(32'h1004);
    chk("t1_not_empty", 64'(empty_o), 64'd0);
    tick();
    chk("t1_req_v", 64'(dma_req_v_o), 64'd1);
    chk("t1_req_addr", 64'(dma_req_addr_o), 64'h1000);
    tick();
    dma_resp_v_i = 1'b1; dma_resp_data_i = 32'hDEADBEEF;
    exp_fill_addr.push_back(32'h1000);
    exp_fill_data.push_back(32'hDEADBEEF);
    tick();
    dma_resp_v_i = 1'b0;
    chk("t1_fill_v", 64'(fill_v_o), 64'd1);
    chk("t1_fill_addr", 64'(fill_addr_o), 64'h1000);
    chk("t1_fill_data", 64'(fill_data_o), 64'hDEADBEEF);
    tick();
    chk("t1_fill_once", 64'(fill_v_o), 64'd0);
    chk("t1_empty", 64'(empty_o), 64'd1);

    // Fill the queue with ready low; fifth request overflows.
    dma_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'(i * 32'h40));
      pf(32'(i * 32'h40));
      chk("t2_hold_addr", 64'(dma_req_addr_o), 64'h0);
      chk("t2_full_timing", 64'(full_o), 64'(i == 3));
    end
    pf(32'h100);
    chk("t2_drop", 64'(drop_count_o), 64'd1);
    chk("t2_req_v", 64'(dma_req_v_o), 64'd1);
    chk("t2_hold_addr_end", 64'(dma_req_addr_o), 64'h0);
    for (int i = 0; i < 4; i++) serve_one(32'(i * 32'h40), 32'hA5A50000 | 32'(i));
    chk("t2_empty", 64'(empty_o), 64'd1);

    // Same-line prefetches collapse into one request.
    exp_req.push_back(32'h200);
    pf(32'h200);
    pf(32'h23C);
    serve_one(32'h200, 32'h12345678);
    repeat (3) tick();
    chk("t3_no_extra_req", 64'(dma_req_v_o), 64'd0);
    chk("t3_drop_unchanged", 64'(drop_count_o), 64'd1);

    // Demand miss cancels a queued line but never the head under request.
    dma_req_ready_i = 1'b0;
    exp_req.push_back(32'h300);
    pf(32'h300);
    pf(32'h340);
    demand_miss_v_i = 1'b1; demand_miss_addr_i = 32'h348;
    tick();
    demand_miss_addr_i = 32'h308;
    tick();
    demand_miss_v_i = 1'b0;
    chk("t4_head_req", 64'(dma_req_addr_o), 64'h300);
    serve_one(32'h300, 32'h0BADF00D);
    repeat (4) tick();
    chk("t4_no_req", 64'(dma_req_v_o), 64'd0);
    chk("t4_empty", 64'(empty_o), 64'd1);

    // Full queue: pop and enqueue in the same cycle still drops.
    dma_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'h400 + 32'(i * 32'h40));
      pf(32'h400 + 32'(i * 32'h40));
    end
    chk("t5_full", 64'(full_o), 64'd1);
    dma_req_ready_i = 1'b1;
    pf(32'h500);
    chk("t5_drop", 64'(drop_count_o), 64'd2);
    chk("t5_not_full", 64'(full_o), 64'd0);
    chk("t5_not_empty", 64'(empty_o), 64'd0);
    dma_resp_v_i = 1'b1; dma_resp_data_i = 32'h44440000;
    exp_fill_addr.push_back(32'h400);
    exp_fill_data.push_back(32'h44440000);
    tick();
    dma_resp_v_i = 1'b0;
    tick();
    for (int i = 1; i < 4; i++) serve_one(32'h400 + 32'(i * 32'h40), 32'h44440000 | 32'(i));
    repeat (2) tick();
    chk("t5_empty", 64'(empty_o), 64'd1);

    // Reset while waiting for a response; a late response is ignored.
    dma_req_ready_i = 1'b1;
    exp_req.push_back(32'h600);
    pf(32'h600);
    tick();
    tick();
    chk("t6_wait_no_req", 64'(dma_req_v_o), 64'd0);
    reset_n_i = 1'b0;
    #1;
    chk("t6_rst_empty", 64'(empty_o), 64'd1);
    chk("t6_rst_drop", 64'(drop_count_o), 64'd0);
    tick();
    reset_n_i = 1'b1;
    tick();
    dma_resp_v_i = 1'b1; dma_resp_data_i = 32'hFEEDFACE;
    tick();
    dma_resp_v_i = 1'b0;
    chk("t6_no_fill", 64'(fill_v_o), 64'd0);
    tick();
    chk("t6_no_fill2", 64'(fill_v_o), 64'd0);
    chk("t6_empty", 64'(empty_o), 64'd1);

    chk("sb_req_drained", 64'(exp_req.size()), 64'd0);
    chk("sb_fill_drained", 64'(exp_fill_addr.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
